// File: rtl/mod_74x08_bist_n_if.sv
// Bus interface for mod_74x08_bist_n: gate inputs/outputs and BIST control/status.
// MOD_74X08_BIST_FAULT_INJ_EN adds the fault_mask signal.
interface mod_74x08_bist_n_if #(
  parameter int N = 4
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [N-1:0]  y;
  logic          bist_start;
  logic          bist_busy;
  logic          bist_done;
  logic          bist_pass;
  logic [CW-1:0] bist_fail_ch;
`ifdef MOD_74X08_BIST_FAULT_INJ_EN
  logic [N-1:0]  fault_mask;
`endif

  modport master (
`ifdef MOD_74X08_BIST_FAULT_INJ_EN
    output fault_mask,
`endif
    output a, b, bist_start,
    input  y, bist_busy, bist_done, bist_pass, bist_fail_ch
  );

  modport slave (
`ifdef MOD_74X08_BIST_FAULT_INJ_EN
    input  fault_mask,
`endif
    input  a, b, bist_start,
    output y, bist_busy, bist_done, bist_pass, bist_fail_ch
  );
endinterface

// File: rtl/mod_74x08_bist_n.sv
// N-channel 2-input AND bank with registered outputs and a BIST sequencer that
// walks each channel through 11/01/10/00 and reports the first failing channel.
// Optional: MOD_74X08_BIST_FAULT_INJ_EN adds fault_mask (stuck-at-1 per channel).
module mod_74x08_bist_n #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mod_74x08_bist_n_if.slave    bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] ch;
  logic [1:0]    vec;
  logic [N-1:0]  r;

  logic          bist_mode;
  logic          vec_a;
  logic          vec_b;
  logic          vec_exp;
  logic          r_sel;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [N-1:0]  gate;
  logic [N-1:0]  stuck;

  assign bist_mode = (state == APPLY) || (state == CHECK);

  // vec 0:11, 1:01, 2:10, 3:00 (a,b); only vec 0 yields a 1
  assign vec_a   = ~vec[0];
  assign vec_b   = ~vec[1];
  assign vec_exp = (vec == 2'd0);

`ifdef MOD_74X08_BIST_FAULT_INJ_EN
  assign stuck = bus.fault_mask;
`else
  assign stuck = '0;
`endif

  // Shared gate array: functional inputs, or the test vector on channel ch only
  always_comb begin
    in_a = '0;
    in_b = '0;
    if (bist_mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (32'(ch) == i) begin
          in_a[i] = vec_a;
          in_b[i] = vec_b;
        end
      end
    end else begin
      in_a = bus.a;
      in_b = bus.b;
    end
    gate = (in_a & in_b) | stuck;
  end

  // Select the captured result of the channel under test
  always_comb begin
    r_sel = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(ch) == i) r_sel = r[i];
    end
  end

  // BIST sequencer, status registers and registered gate outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ch               <= '0;
      vec              <= '0;
      r                <= '0;
      bus.y            <= '0;
      bus.bist_busy    <= 1'b0;
      bus.bist_done    <= 1'b0;
      bus.bist_pass    <= 1'b0;
      bus.bist_fail_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.y <= gate;
          if (bus.bist_start) begin
            state            <= APPLY;
            ch               <= '0;
            vec              <= '0;
            bus.bist_busy    <= 1'b1;
            bus.bist_pass    <= 1'b0;
            bus.bist_fail_ch <= '0;
          end
        end
        APPLY: begin
          r     <= gate;
          state <= CHECK;
        end
        CHECK: begin
          if (r_sel != vec_exp) begin
            state            <= DONE;
            bus.bist_busy    <= 1'b0;
            bus.bist_done    <= 1'b1;
            bus.bist_pass    <= 1'b0;
            bus.bist_fail_ch <= ch;
          end else if (vec != 2'd3) begin
            vec   <= vec + 2'd1;
            state <= APPLY;
          end else if (ch != CW'(N - 1)) begin
            ch    <= ch + 1'b1;
            vec   <= '0;
            state <= APPLY;
          end else begin
            state            <= DONE;
            bus.bist_busy    <= 1'b0;
            bus.bist_done    <= 1'b1;
            bus.bist_pass    <= 1'b1;
            bus.bist_fail_ch <= '0;
          end
        end
        DONE: begin
          bus.y         <= gate;
          bus.bist_done <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
